replacement_policy_unit: RTL and testbench



---
 rtl/iob_cache_rp_pkg.sv | 35 +++
 rtl/replacement_policy_unit_rp_next_state.sv | 80 ++++++++
 rtl/replacement_policy_unit.sv | 154 +++++++++++++++
 tb/tb_replacement_policy_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_rp_pkg.sv
// Shared encodings and helpers for the cache replacement-policy unit.
package iob_cache_rp_pkg;

  localparam logic [1:0] LRU       = 2'd0;
  localparam logic [1:0] PLRU_MRU  = 2'd1;
  localparam logic [1:0] PLRU_TREE = 2'd2;
  localparam logic [1:0] RANDOM    = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } rp_fsm_e;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // bits 15, 13, 12, 10

  // Per-set state is sized for LRU, the widest policy.
  function automatic int unsigned state_w(input int unsigned n_ways);
    return n_ways * $clog2(n_ways);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic int unsigned onehot_to_bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (1'(oh >> (i - 1))) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/replacement_policy_unit_rp_next_state.sv
// Combinational policy kernel: next per-set state after a hit, and victim of the old state.
module rp_next_state
  import iob_cache_rp_pkg::*;
#(
  parameter int unsigned N_WAYS  = 4,
  parameter int unsigned NWAY_W  = $clog2(N_WAYS),
  parameter int unsigned STATE_W = N_WAYS * NWAY_W
) (
  input  logic [1:0]         policy_i,
  input  logic [STATE_W-1:0] old_state_i,
  input  logic [N_WAYS-1:0]  hit_i,
  output logic [STATE_W-1:0] new_state_o,
  output logic [N_WAYS-1:0]  victim_o
);

  always_comb begin
    int unsigned h;
    int unsigned node;
    int unsigned unode;
    logic              found;
    logic [NWAY_W-1:0] h_rank;
    logic [NWAY_W-1:0] rank;
    logic [N_WAYS-1:0] mru;
    new_state_o = old_state_i;
    victim_o    = '0;
    h           = 0;
    node        = 1;
    unode       = 0;
    found       = 1'b0;
    h_rank      = '0;
    rank        = '0;
    mru         = '0;
    for (int unsigned i = N_WAYS; i > 0; i--) begin
      if (1'(hit_i >> (i - 1))) h = i - 1;
    end
    case (policy_i)
      LRU: begin
        h_rank = NWAY_W'(old_state_i >> (h * NWAY_W));
        for (int unsigned i = 0; i < N_WAYS; i++) begin
          rank = NWAY_W'(old_state_i >> (i * NWAY_W));
          if (rank == '0 && !found) begin
            victim_o = N_WAYS'(1) << i;
            found    = 1'b1;
          end
          if (i == h) rank = NWAY_W'(N_WAYS - 1);
          else if (rank > h_rank) rank = rank - NWAY_W'(1);
          new_state_o = (new_state_o & ~(STATE_W'({NWAY_W{1'b1}}) << (i * NWAY_W)))
                      | (STATE_W'(rank) << (i * NWAY_W));
        end
        if (!found) victim_o = N_WAYS'(1);
      end
      PLRU_MRU: begin
        mru = N_WAYS'(old_state_i) | hit_i;
        new_state_o[N_WAYS-1:0] = (&mru) ? hit_i : mru;
        for (int unsigned i = 0; i < N_WAYS; i++) begin
          if (!1'(old_state_i >> i) && !found) begin
            victim_o = N_WAYS'(1) << i;
            found    = 1'b1;
          end
        end
        if (!found) victim_o = N_WAYS'(1);
      end
      PLRU_TREE: begin
        // Node k lives at bit k (heap order, bit 0 unused); 1 points to the upper half.
        for (int unsigned lvl = 0; lvl < NWAY_W; lvl++) begin
          if (1'(old_state_i >> node)) node = 2 * node + 1;
          else node = 2 * node;
        end
        victim_o = N_WAYS'(1) << (node - N_WAYS);
        for (int unsigned lvl = 0; lvl < NWAY_W; lvl++) begin
          unode = (h + N_WAYS) >> (NWAY_W - lvl);
          if (1'(h >> (NWAY_W - 1 - lvl))) new_state_o = new_state_o & ~(STATE_W'(1) << unode);
          else new_state_o = new_state_o | (STATE_W'(1) << unode);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/replacement_policy_unit.sv
// Run-time selectable victim-way selector with per-set state, lookup/update ports and init sweep.
module replacement_policy_unit
  import iob_cache_rp_pkg::*;
#(
  parameter int unsigned N_WAYS     = 4,
  parameter int unsigned LINE_OFF_W = 7,
  parameter int unsigned NWAY_W     = $clog2(N_WAYS),
  parameter int unsigned STATE_W    = state_w(N_WAYS),
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            policy_sel,
  input  logic                  flush,
  output logic                  busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LINE_OFF_W-1:0] req_addr,
  output logic                  rsp_valid,
  output logic [N_WAYS-1:0]     way_select,
  output logic [NWAY_W-1:0]     way_select_bin,
  input  logic                  upd_valid,
  input  logic [LINE_OFF_W-1:0] upd_addr,
  input  logic [N_WAYS-1:0]     upd_way_hit
);

  localparam int unsigned N_SETS = 2 ** LINE_OFF_W;

  rp_fsm_e               state_q, state_d;
  logic [LINE_OFF_W-1:0] cnt_q, cnt_d;
  logic [1:0]            policy_q, policy_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic                  busy_q, busy_d;
  logic                  rsp_q, rsp_d;
  logic [N_WAYS-1:0]     way_q, way_d;
  logic [NWAY_W-1:0]     bin_q, bin_d;
  logic [STATE_W-1:0]    mem_q [N_SETS];

  logic [1:0]            eff_policy_c;
  logic                  accept_c;
  logic                  upd_we_c;
  logic [N_WAYS-1:0]     hit_lsb_c;
  logic [STATE_W-1:0]    upd_new_c;
  logic [N_WAYS-1:0]     upd_victim_c;
  logic [STATE_W-1:0]    lk_state_c;
  logic [STATE_W-1:0]    lk_new_c;
  logic [N_WAYS-1:0]     lk_victim_c;
  logic [N_WAYS-1:0]     victim_c;
  logic [STATE_W-1:0]    init_val_c;
  logic                  unused_ok_c;

  // The first sweep cycle latches the requested policy.
  assign eff_policy_c = (state_q == INIT && cnt_q == '0) ? policy_sel : policy_q;
  assign accept_c     = req_valid && !busy_q;
  assign upd_we_c     = (state_q == IDLE) && upd_valid && (|upd_way_hit);
  assign hit_lsb_c    = upd_way_hit & (~upd_way_hit + N_WAYS'(1));

  rp_next_state #(.N_WAYS(N_WAYS), .NWAY_W(NWAY_W), .STATE_W(STATE_W)) u_upd (
    .policy_i    (policy_q),
    .old_state_i (mem_q[upd_addr]),
    .hit_i       (hit_lsb_c),
    .new_state_o (upd_new_c),
    .victim_o    (upd_victim_c)
  );

  // A same-cycle update to the looked-up set is forwarded into the decode.
  assign lk_state_c = (upd_we_c && upd_addr == req_addr) ? upd_new_c : mem_q[req_addr];

  rp_next_state #(.N_WAYS(N_WAYS), .NWAY_W(NWAY_W), .STATE_W(STATE_W)) u_lookup (
    .policy_i    (policy_q),
    .old_state_i (lk_state_c),
    .hit_i       ('0),
    .new_state_o (lk_new_c),
    .victim_o    (lk_victim_c)
  );

  assign victim_c    = (policy_q == RANDOM) ? (N_WAYS'(1) << lfsr_q[NWAY_W-1:0]) : lk_victim_c;
  assign unused_ok_c = ^{lk_new_c, upd_victim_c};

  always_comb begin
    init_val_c = '0;
    if (eff_policy_c == LRU) begin
      for (int unsigned i = 0; i < N_WAYS; i++) begin
        init_val_c = init_val_c | (STATE_W'(i) << (i * NWAY_W));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    policy_d = eff_policy_c;
    lfsr_d   = lfsr_q;
    rsp_d    = 1'b0;
    way_d    = way_q;
    bin_d    = bin_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + LINE_OFF_W'(1);
        if (flush) cnt_d = '0;
        else if (cnt_q == LINE_OFF_W'(N_SETS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (flush || policy_sel != policy_q) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
    busy_d = (state_d == INIT);
    if (accept_c) begin
      rsp_d = 1'b1;
      way_d = victim_c;
      bin_d = NWAY_W'(onehot_to_bin(32'(victim_c)));
      if (policy_q == RANDOM) lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      policy_q <= LRU;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b1;
      rsp_q    <= 1'b0;
      way_q    <= '0;
      bin_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      policy_q <= policy_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      rsp_q    <= rsp_d;
      way_q    <= way_d;
      bin_q    <= bin_d;
    end
  end

  // Policy state array: defined by the sweep, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem_q[cnt_q] <= init_val_c;
    else if (upd_we_c) mem_q[upd_addr] <= upd_new_c;
  end

  assign busy           = busy_q;
  assign req_ready      = ~busy_q;
  assign rsp_valid      = rsp_q;
  assign way_select     = way_q;
  assign way_select_bin = bin_q;

endmodule

// File: tb/tb_replacement_policy_unit.sv
// Scoreboarded bench for replacement_policy_unit at default parameters (4 ways, 128 sets).
module tb_replacement_policy_unit;

  logic       clk;
  logic       reset;
  logic [1:0] policy_sel;
  logic       flush;
  logic       busy;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic       rsp_valid;
  logic [3:0] way_select;
  logic [1:0] way_select_bin;
  logic       upd_valid;
  logic [6:0] upd_addr;
  logic [3:0] upd_way_hit;

  typedef struct packed {
    logic [3:0] oh;
    logic [1:0] bin;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] lfsr_m;

  replacement_policy_unit dut (
    .clk            (clk),
    .reset          (reset),
    .policy_sel     (policy_sel),
    .flush          (flush),
    .busy           (busy),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .way_select     (way_select),
    .way_select_bin (way_select_bin),
    .upd_valid      (upd_valid),
    .upd_addr       (upd_addr),
    .upd_way_hit    (upd_way_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] oh);
    exp_t e;
    e.oh  = oh;
    e.bin = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) e.bin = 2'(i);
    return e;
  endfunction

  // Response monitor: every rsp_valid pops one expected entry.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: got way_select=%b bin=%0d with nothing expected", way_select, way_select_bin);
      end else begin
        e = exp_q.pop_front();
        if (way_select !== e.oh || way_select_bin !== e.bin) begin
          n_err++;
          $display("FAIL lookup_rsp: got %b/%0d expected %b/%0d", way_select, way_select_bin, e.oh, e.bin);
        end
      end
    end
  end

  task automatic lookup(input logic [6:0] a, input logic [3:0] oh);
    req_valid = 1'b1;
    req_addr  = a;
    exp_q.push_back(mk_exp(oh));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rand_lookup(input logic [6:0] a);
    lookup(a, 4'b0001 << lfsr_m[1:0]);
    lfsr_m = lfsr_step(lfsr_m);
  endtask

  task automatic hit(input logic [6:0] a, input logic [3:0] h);
    upd_valid   = 1'b1;
    upd_addr    = a;
    upd_way_hit = h;
    @(negedge clk);
    upd_valid   = 1'b0;
    upd_way_hit = 4'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic change_policy(input logic [1:0] p, output int n);
    policy_sel = p;
    @(negedge clk);
    count_busy(n);
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || way_select !== 4'b0 || way_select_bin !== 2'b0 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b rsp=%b way=%b bin=%0d ready=%b expected 1 0 0000 0 0",
               busy, rsp_valid, way_select, way_select_bin, req_ready);
    end
    reset = 1'b1;
    count_busy(n);
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL reset_sweep_len: got %0d cycles expected 128", n); end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_sweep: got %b expected 1", req_ready); end
    lookup(7'd5, 4'b0001);
  endtask

  task automatic test_lru;
    hit(7'd5, 4'b0001);
    hit(7'd5, 4'b0010);
    hit(7'd5, 4'b0100);
    lookup(7'd5, 4'b1000);
    hit(7'd5, 4'b1000);
    lookup(7'd5, 4'b0001);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || way_select !== 4'b0001) begin
      n_err++;
      $display("FAIL hold_way: rsp=%b way=%b expected 0 0001", rsp_valid, way_select);
    end
    lookup(7'd6, 4'b0001);
    hit(7'd7, 4'b0000);
    lookup(7'd7, 4'b0001);
  endtask

  task automatic test_flush_and_busy_update;
    int n;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_mid_sweep: got %b expected 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      upd_valid   = (n == 20);
      upd_addr    = 7'd2;
      upd_way_hit = 4'b0001;
      n++;
      @(negedge clk);
    end
    upd_valid   = 1'b0;
    upd_way_hit = 4'b0;
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL flush_sweep_len: got %0d cycles expected 128", n); end
    lookup(7'd2, 4'b0001);
  endtask

  task automatic test_plru_mru;
    int n;
    change_policy(2'd1, n);
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL mru_sweep_len: got %0d expected 128", n); end
    hit(7'd5, 4'b0001);
    hit(7'd5, 4'b0010);
    hit(7'd5, 4'b0100);
    lookup(7'd5, 4'b1000);
    hit(7'd5, 4'b1000);
    lookup(7'd5, 4'b0001);
    hit(7'd5, 4'b0011);
    lookup(7'd5, 4'b0010);
  endtask

  task automatic test_plru_tree;
    int n;
    change_policy(2'd2, n);
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL tree_sweep_len: got %0d expected 128", n); end
    hit(7'd5, 4'b0001);
    lookup(7'd5, 4'b0100);
    hit(7'd5, 4'b0100);
    lookup(7'd5, 4'b0010);
    upd_valid   = 1'b1;
    upd_addr    = 7'd5;
    upd_way_hit = 4'b0010;
    lookup(7'd5, 4'b1000);
    upd_valid   = 1'b0;
    upd_way_hit = 4'b0;
  endtask

  task automatic test_random;
    int n;
    change_policy(2'd0, n);
    change_policy(2'd3, n);
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL random_sweep_len: got %0d expected 128", n); end
    lfsr_m = 16'hACE1;
    lookup(7'd10, 4'b0010);
    lfsr_m = lfsr_step(lfsr_m);
    rand_lookup(7'd11);
  endtask

  task automatic test_back_to_back;
    int n;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 7'(k + 20);
      exp_q.push_back(mk_exp(4'b0001 << lfsr_m[1:0]));
      lfsr_m = lfsr_step(lfsr_m);
      @(negedge clk);
    end
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    count_busy(n);
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL flush_idle_sweep_len: got %0d expected 128", n); end
    rand_lookup(7'd30);
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 7'd9;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: rsp=%b busy=%b expected 1 1", rsp_valid, busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || way_select !== 4'b0 || way_select_bin !== 2'b0) begin
      n_err++;
      $display("FAIL mid_sweep_reset: rsp=%b busy=%b way=%b bin=%0d expected 0 1 0000 0",
               rsp_valid, busy, way_select, way_select_bin);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lfsr_m = 16'hACE1;
    count_busy(n);
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL restart_sweep_len: got %0d expected 128", n); end
    rand_lookup(7'd1);
  endtask

  initial begin
    policy_sel  = 2'd0;
    flush       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = 7'd0;
    upd_valid   = 1'b0;
    upd_addr    = 7'd0;
    upd_way_hit = 4'b0;
    lfsr_m      = 16'hACE1;
    test_reset();
    test_lru();
    test_flush_and_busy_update();
    test_plru_mru();
    test_plru_tree();
    test_random();
    test_back_to_back();
    test_reset_mid_sweep();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_rsp: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
